// File: rtl/ecc_scrub_ctrl.sv
// Host-read / background-scrub sequencer around a shared external Hamming(71,64) decoder.
// Optional define HOST_WB_EN: host reads with a corrected error also write the repaired word back.
module ecc_scrub_ctrl #(
    parameter int ADDR_W       = 10,
    parameter int SCRUB_PERIOD = 1024,
    parameter int CNT_W        = 16,
    parameter int STARVE_MAX   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              host_req_valid,
    output logic              host_req_ready,
    input  logic [ADDR_W-1:0] host_req_addr,
    output logic              host_resp_valid,
    output logic [63:0]       host_resp_data,
    output logic              host_resp_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [70:0]       mem_wdata,
    input  logic [70:0]       mem_rdata,
    output logic [70:0]       dec_codeword,
    input  logic [63:0]       dec_data,
    input  logic [6:0]        dec_syndrome,
    output logic [63:0]       enc_data,
    input  logic [70:0]       enc_codeword,
    input  logic              scrub_en,
    output logic              scrub_pass_done,
    output logic [CNT_W-1:0]  corr_cnt,
    output logic [CNT_W-1:0]  uncorr_cnt,
    output logic [ADDR_W-1:0] last_err_addr
);

    localparam int TMR_W = $clog2(SCRUB_PERIOD);
    localparam int STV_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    typedef enum logic [2:0] {IDLE, RD, WAIT, DEC, RESP, WB} state_t;

    state_t             state_q, state_d;
    logic               is_scrub_q, is_scrub_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [70:0]        cw_q, cw_d;
    logic [63:0]        enc_data_q, enc_data_d;
    logic               scrub_pend_q, scrub_pend_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [STV_W-1:0]   starve_q, starve_d;
    logic [ADDR_W-1:0]  scrub_addr_q, scrub_addr_d;
    logic               pass_done_q, pass_done_d;
    logic [CNT_W-1:0]   corr_cnt_q, corr_cnt_d;
    logic [CNT_W-1:0]   uncorr_cnt_q, uncorr_cnt_d;
    logic [ADDR_W-1:0]  last_err_addr_q, last_err_addr_d;
    logic               resp_valid_q, resp_valid_d;
    logic [63:0]        resp_data_q, resp_data_d;
    logic               resp_err_q, resp_err_d;
    logic               mem_en_q, mem_en_d;
    logic               mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
`ifdef HOST_WB_EN
    logic               corr_q, corr_d;
`endif

    logic scrub_win, tmr_fire, syn_corr, syn_uncorr, scrub_done;

    // Scrub only jumps ahead of a waiting host once that host has had its quota.
    assign scrub_win  = scrub_pend_q && (!host_req_valid || starve_q == STV_W'(STARVE_MAX));
    assign tmr_fire   = scrub_en && (timer_q == TMR_W'(SCRUB_PERIOD - 1));
    assign syn_corr   = (dec_syndrome != 7'd0) && (dec_syndrome <= 7'd71);
    assign syn_uncorr = (dec_syndrome >= 7'd72);

    always_comb begin
        state_d         = state_q;
        is_scrub_d      = is_scrub_q;
        addr_d          = addr_q;
        cw_d            = cw_q;
        enc_data_d      = enc_data_q;
        scrub_pend_d    = scrub_pend_q;
        timer_d         = timer_q;
        starve_d        = starve_q;
        scrub_addr_d    = scrub_addr_q;
        pass_done_d     = 1'b0;
        corr_cnt_d      = corr_cnt_q;
        uncorr_cnt_d    = uncorr_cnt_q;
        last_err_addr_d = last_err_addr_q;
        resp_valid_d    = 1'b0;
        resp_data_d     = resp_data_q;
        resp_err_d      = resp_err_q;
        mem_en_d        = 1'b0;
        mem_we_d        = 1'b0;
        mem_addr_d      = mem_addr_q;
`ifdef HOST_WB_EN
        corr_d          = corr_q;
`endif
        scrub_done      = 1'b0;

        if (scrub_en) timer_d = tmr_fire ? '0 : timer_q + TMR_W'(1);

        case (state_q)
            IDLE: begin
                if (scrub_win) begin
                    state_d      = RD;
                    is_scrub_d   = 1'b1;
                    addr_d       = scrub_addr_q;
                    starve_d     = '0;
                    scrub_pend_d = 1'b0;
                    mem_en_d     = 1'b1;
                    mem_addr_d   = scrub_addr_q;
                end else if (host_req_valid) begin
                    state_d    = RD;
                    is_scrub_d = 1'b0;
                    addr_d     = host_req_addr;
                    if (scrub_pend_q) starve_d = starve_q + STV_W'(1);
                    mem_en_d   = 1'b1;
                    mem_addr_d = host_req_addr;
                end
            end
            RD:   state_d = WAIT;
            WAIT: begin
                cw_d    = mem_rdata;
                state_d = DEC;
            end
            DEC: begin
`ifdef HOST_WB_EN
                corr_d = syn_corr;
`endif
                if (syn_corr) begin
                    if (corr_cnt_q != '1) corr_cnt_d = corr_cnt_q + CNT_W'(1);
                    last_err_addr_d = addr_q;
                end
                if (syn_uncorr) begin
                    if (uncorr_cnt_q != '1) uncorr_cnt_d = uncorr_cnt_q + CNT_W'(1);
                    last_err_addr_d = addr_q;
                end
                if (!is_scrub_q) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_data_d  = dec_data;
                    resp_err_d   = syn_uncorr;
                end else if (syn_corr) begin
                    state_d    = WB;
                    mem_en_d   = 1'b1;
                    mem_we_d   = 1'b1;
                    mem_addr_d = addr_q;
                    enc_data_d = dec_data;
                end else begin
                    state_d    = IDLE;
                    scrub_done = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
`ifdef HOST_WB_EN
                if (corr_q) begin
                    state_d    = WB;
                    mem_en_d   = 1'b1;
                    mem_we_d   = 1'b1;
                    mem_addr_d = addr_q;
                    enc_data_d = resp_data_q;
                end
`endif
            end
            WB: begin
                state_d    = IDLE;
                scrub_done = is_scrub_q;
            end
            default: state_d = IDLE;
        endcase

        // A timer expiry coinciding with a scrub grant must not be lost.
        if (tmr_fire) scrub_pend_d = 1'b1;

        if (scrub_done) begin
            scrub_addr_d = scrub_addr_q + ADDR_W'(1);
            pass_done_d  = &scrub_addr_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            is_scrub_q      <= 1'b0;
            addr_q          <= '0;
            cw_q            <= '0;
            enc_data_q      <= '0;
            scrub_pend_q    <= 1'b0;
            timer_q         <= '0;
            starve_q        <= '0;
            scrub_addr_q    <= '0;
            pass_done_q     <= 1'b0;
            corr_cnt_q      <= '0;
            uncorr_cnt_q    <= '0;
            last_err_addr_q <= '0;
            resp_valid_q    <= 1'b0;
            resp_data_q     <= '0;
            resp_err_q      <= 1'b0;
            mem_en_q        <= 1'b0;
            mem_we_q        <= 1'b0;
            mem_addr_q      <= '0;
`ifdef HOST_WB_EN
            corr_q          <= 1'b0;
`endif
        end else begin
            state_q         <= state_d;
            is_scrub_q      <= is_scrub_d;
            addr_q          <= addr_d;
            cw_q            <= cw_d;
            enc_data_q      <= enc_data_d;
            scrub_pend_q    <= scrub_pend_d;
            timer_q         <= timer_d;
            starve_q        <= starve_d;
            scrub_addr_q    <= scrub_addr_d;
            pass_done_q     <= pass_done_d;
            corr_cnt_q      <= corr_cnt_d;
            uncorr_cnt_q    <= uncorr_cnt_d;
            last_err_addr_q <= last_err_addr_d;
            resp_valid_q    <= resp_valid_d;
            resp_data_q     <= resp_data_d;
            resp_err_q      <= resp_err_d;
            mem_en_q        <= mem_en_d;
            mem_we_q        <= mem_we_d;
            mem_addr_q      <= mem_addr_d;
`ifdef HOST_WB_EN
            corr_q          <= corr_d;
`endif
        end
    end

    assign host_req_ready  = rst_n && (state_q == IDLE) && !scrub_win;
    assign host_resp_valid = resp_valid_q;
    assign host_resp_data  = resp_data_q;
    assign host_resp_err   = resp_err_q;
    assign mem_en          = mem_en_q;
    assign mem_we          = mem_we_q;
    assign mem_addr        = mem_addr_q;
    assign mem_wdata       = mem_we_q ? enc_codeword : '0;
    assign dec_codeword    = cw_q;
    assign enc_data        = enc_data_q;
    assign scrub_pass_done = pass_done_q;
    assign corr_cnt        = corr_cnt_q;
    assign uncorr_cnt      = uncorr_cnt_q;
    assign last_err_addr   = last_err_addr_q;

endmodule

// File: tb/tb_ecc_scrub_ctrl.sv
// Randomized bench for ecc_scrub_ctrl: behavioural memory/codec plus a transaction-level expectation model.
module tb_ecc_scrub_ctrl;

    localparam int ADDR_W = 2;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 2;
    localparam int SMAX   = 4;
    localparam int CMAX   = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic host_req_valid = 1'b0;
    logic host_req_ready;
    logic [ADDR_W-1:0] host_req_addr = '0;
    logic host_resp_valid;
    logic [63:0] host_resp_data;
    logic host_resp_err;
    logic mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [70:0] mem_wdata;
    logic [70:0] mem_rdata = '0;
    logic [70:0] dec_codeword;
    logic [63:0] dec_data;
    logic [6:0]  dec_syndrome;
    logic [63:0] enc_data;
    logic [70:0] enc_codeword;
    logic scrub_en = 1'b0;
    logic scrub_pass_done;
    logic [CNT_W-1:0] corr_cnt, uncorr_cnt;
    logic [ADDR_W-1:0] last_err_addr;

    ecc_scrub_ctrl #(.ADDR_W(ADDR_W), .SCRUB_PERIOD(2), .CNT_W(CNT_W), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .host_req_valid(host_req_valid), .host_req_ready(host_req_ready), .host_req_addr(host_req_addr),
        .host_resp_valid(host_resp_valid), .host_resp_data(host_resp_data), .host_resp_err(host_resp_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .dec_codeword(dec_codeword), .dec_data(dec_data), .dec_syndrome(dec_syndrome),
        .enc_data(enc_data), .enc_codeword(enc_codeword),
        .scrub_en(scrub_en), .scrub_pass_done(scrub_pass_done),
        .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt), .last_err_addr(last_err_addr)
    );

    always #5 clk = ~clk;

    // Toy code: check bits are a fold of the data; syndrome is stored-check xor recomputed-check.
    function automatic logic [6:0] chk(input logic [63:0] d);
        return d[6:0] ^ d[63:57] ^ d[38:32] ^ 7'h2a;
    endfunction
    function automatic logic [70:0] mk(input logic [63:0] d, input logic [6:0] s);
        return {chk(d) ^ s, d};
    endfunction

    assign enc_codeword = {chk(enc_data), enc_data};
    assign dec_data     = dec_codeword[63:0];
    assign dec_syndrome = dec_codeword[70:64] ^ chk(dec_codeword[63:0]);

    logic [70:0] mem [DEPTH];
    logic bd_en = 1'b0;
    logic [ADDR_W-1:0] bd_addr = '0;
    logic [70:0] bd_data = '0;

    always @(posedge clk) begin
        if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
        else if (bd_en) mem[bd_addr] <= bd_data;
        if (mem_en && !mem_we) mem_rdata <= mem[mem_addr];
    end

    // Bus monitor: write log, scrub-read log (reads not preceded by a host accept), pass pulses.
    int wr_cnt = 0, pass_cnt = 0;
    logic [ADDR_W-1:0] last_wr_addr = '0;
    logic [70:0] last_wr_data = '0;
    logic [ADDR_W-1:0] scrub_q[$];
    logic mon_acc = 1'b0;
    always begin
        @(negedge clk);
        #2;
        if (mem_en && mem_we) begin
            wr_cnt++;
            last_wr_addr = mem_addr;
            last_wr_data = mem_wdata;
        end
        if (mem_en && !mem_we && !mon_acc) scrub_q.push_back(mem_addr);
        if (scrub_pass_done) pass_cnt++;
        mon_acc = host_req_valid && host_req_ready;
    end

    int errs = 0, checks = 0;
    int exp_corr = 0, exp_uncorr = 0;
    logic [ADDR_W-1:0] exp_last = '0;
    logic [6:0]  syn [DEPTH];
    logic [63:0] dat [DEPTH];

    function automatic void note_err(input logic [ADDR_W-1:0] a, input logic [6:0] s);
        if (s != 7'd0 && s <= 7'd71) begin
            if (exp_corr < CMAX) exp_corr++;
            exp_last = a;
        end else if (s >= 7'd72) begin
            if (exp_uncorr < CMAX) exp_uncorr++;
            exp_last = a;
        end
    endfunction

    function automatic logic [6:0] rand_syn(input int cls);
        if (cls == 0) return 7'd0;
        if (cls == 1) return 7'($urandom_range(1, 71));
        return 7'($urandom_range(72, 127));
    endfunction

    task automatic poke(input logic [ADDR_W-1:0] a, input logic [63:0] d, input logic [6:0] s);
        @(negedge clk);
        bd_en = 1'b1; bd_addr = a; bd_data = mk(d, s);
        syn[a] = s; dat[a] = d;
        @(negedge clk);
        bd_en = 1'b0;
    endtask

    task automatic host_read(input logic [ADDR_W-1:0] a, output logic [63:0] d, output logic e, output int lat);
        int w;
        @(negedge clk);
        host_req_valid = 1'b1; host_req_addr = a;
        #1;
        w = 0;
        while (!host_req_ready && w < 50) begin
            @(negedge clk); #1; w++;
        end
        @(negedge clk);
        host_req_valid = 1'b0;
        #1;
        lat = 1;
        while (!host_resp_valid && lat < 50) begin
            @(negedge clk); #1; lat++;
        end
        d = host_resp_data;
        e = host_resp_err;
    endtask

    task automatic settle();
        repeat (4) @(negedge clk);
        #3;
    endtask

    task automatic pulse_scrub();
        @(negedge clk);
        scrub_en = 1'b1;
        repeat (2) @(negedge clk);
        scrub_en = 1'b0;
    endtask

    task automatic test_reset();
        for (int a = 0; a < DEPTH; a++) poke(ADDR_W'(a), {$urandom, $urandom}, 7'd0);
        #1;
        checks++; if ({host_resp_valid, host_resp_err, host_req_ready, mem_en, mem_we, scrub_pass_done} !== 6'b0) begin
            errs++; $display("FAIL reset_ctl: got %b exp 000000", {host_resp_valid, host_resp_err, host_req_ready, mem_en, mem_we, scrub_pass_done}); end
        checks++; if ({mem_addr, last_err_addr, corr_cnt, uncorr_cnt} !== 8'd0) begin
            errs++; $display("FAIL reset_cnt: got %h exp 0", {mem_addr, last_err_addr, corr_cnt, uncorr_cnt}); end
        checks++; if ({host_resp_data, mem_wdata, dec_codeword, enc_data} !== '0) begin
            errs++; $display("FAIL reset_data: nonzero data outputs"); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_clean_read();
        logic [63:0] d; logic e; int lat, w0;
        logic [63:0] v = {$urandom, $urandom};
        poke(1, v, 7'd0);
        #3; w0 = wr_cnt;
        host_read(1, d, e, lat);
        checks++; if (lat !== 4) begin errs++; $display("FAIL clean_lat: got %0d exp 4", lat); end
        checks++; if (d !== v || e !== 1'b0) begin errs++; $display("FAIL clean_data: got %h/%b exp %h/0", d, e, v); end
        @(negedge clk); #1;
        checks++; if (host_resp_valid !== 1'b0) begin errs++; $display("FAIL clean_pulse: valid %b exp 0", host_resp_valid); end
        settle();
        checks++; if (host_resp_data !== v) begin errs++; $display("FAIL clean_hold: got %h exp %h", host_resp_data, v); end
        checks++; if (int'(corr_cnt) !== 0 || int'(uncorr_cnt) !== 0 || wr_cnt !== w0) begin
            errs++; $display("FAIL clean_side: corr %0d uncorr %0d writes %0d exp 0 0 0", corr_cnt, uncorr_cnt, wr_cnt - w0); end
    endtask

    task automatic test_host_corr();
        logic [63:0] d; logic e; int lat, w0;
        logic [63:0] v = {$urandom, $urandom};
        logic [6:0] s = 7'($urandom_range(1, 71));
        poke(2, v, s);
        #3; w0 = wr_cnt;
        host_read(2, d, e, lat);
        note_err(2, s);
        checks++; if (lat !== 4 || d !== v || e !== 1'b0) begin
            errs++; $display("FAIL hcorr_resp: lat %0d data %h err %b exp 4 %h 0", lat, d, e, v); end
        settle();
        checks++; if (int'(corr_cnt) !== exp_corr || last_err_addr !== exp_last) begin
            errs++; $display("FAIL hcorr_cnt: corr %0d last %0d exp %0d %0d", corr_cnt, last_err_addr, exp_corr, exp_last); end
`ifdef HOST_WB_EN
        checks++; if (wr_cnt - w0 !== 1 || last_wr_addr !== 2'd2 || last_wr_data !== mk(v, 7'd0)) begin
            errs++; $display("FAIL hcorr_wb: writes %0d addr %0d data %h exp 1 2 %h", wr_cnt - w0, last_wr_addr, last_wr_data, mk(v, 7'd0)); end
        syn[2] = 7'd0;
`else
        checks++; if (wr_cnt - w0 !== 0) begin errs++; $display("FAIL hcorr_nowb: writes %0d exp 0", wr_cnt - w0); end
`endif
        checks++; if (mem[2] !== mk(v, syn[2])) begin errs++; $display("FAIL hcorr_mem: got %h exp %h", mem[2], mk(v, syn[2])); end
    endtask

    task automatic test_uncorr();
        logic [63:0] d; logic e; int lat, w0;
        logic [63:0] v = {$urandom, $urandom};
        poke(3, v, 7'd100);
        #3; w0 = wr_cnt;
        host_read(3, d, e, lat);
        note_err(3, 7'd100);
        checks++; if (e !== 1'b1 || lat !== 4) begin errs++; $display("FAIL uncorr_err: err %b lat %0d exp 1 4", e, lat); end
        settle();
        checks++; if (int'(uncorr_cnt) !== exp_uncorr || int'(corr_cnt) !== exp_corr || last_err_addr !== exp_last) begin
            errs++; $display("FAIL uncorr_cnt: u %0d c %0d last %0d exp %0d %0d %0d", uncorr_cnt, corr_cnt, last_err_addr, exp_uncorr, exp_corr, exp_last); end
        checks++; if (wr_cnt - w0 !== 0) begin errs++; $display("FAIL uncorr_nowb: writes %0d exp 0", wr_cnt - w0); end
    endtask

    task automatic test_scrub_corr();
        int w0, q0;
        logic [63:0] v = {$urandom, $urandom};
        poke(0, v, 7'd13);
        #3; w0 = wr_cnt; q0 = scrub_q.size();
        pulse_scrub();
        repeat (8) @(negedge clk);
        #3;
        note_err(0, 7'd13);
        checks++; if (scrub_q.size() - q0 !== 1 || scrub_q[q0] !== 2'd0) begin
            errs++; $display("FAIL scrub_rd: ops %0d exp 1 at addr 0", scrub_q.size() - q0); end
        checks++; if (wr_cnt - w0 !== 1 || last_wr_addr !== 2'd0 || last_wr_data !== mk(v, 7'd0)) begin
            errs++; $display("FAIL scrub_wb: writes %0d addr %0d data %h exp 1 0 %h", wr_cnt - w0, last_wr_addr, last_wr_data, mk(v, 7'd0)); end
        checks++; if (int'(corr_cnt) !== exp_corr || last_err_addr !== exp_last) begin
            errs++; $display("FAIL scrub_cnt: corr %0d last %0d exp %0d %0d", corr_cnt, last_err_addr, exp_corr, exp_last); end
        syn[0] = 7'd0;
    endtask

    task automatic test_starve();
        int hosts = 0, en_left = 0, q0;
        logic found = 1'b0, pulsed = 1'b0, acc_last = 1'b0, rdy_last = 1'b1, rdy_at = 1'b1;
        poke(1, {$urandom, $urandom}, 7'd0);
        #3; q0 = scrub_q.size();
        @(negedge clk);
        host_req_valid = 1'b1; host_req_addr = 1;
        for (int i = 0; i < 100 && !found; i++) begin
            #1;
            if (i > 0 && mem_en && !mem_we && !acc_last) begin found = 1'b1; rdy_at = rdy_last; end
            acc_last = host_req_valid && host_req_ready;
            rdy_last = host_req_ready;
            if (acc_last) hosts++;
            if (en_left > 0) begin
                en_left--;
                if (en_left == 0) scrub_en = 1'b0;
            end else if (hosts == 1 && !pulsed) begin
                scrub_en = 1'b1; pulsed = 1'b1; en_left = 2;
            end
            if (!found) @(negedge clk);
        end
        host_req_valid = 1'b0;
        scrub_en = 1'b0;
        repeat (10) @(negedge clk);
        #3;
        checks++; if (found !== 1'b1 || hosts !== SMAX + 1) begin
            errs++; $display("FAIL starve_cnt: found %b host grants %0d exp 1 %0d", found, hosts, SMAX + 1); end
        checks++; if (rdy_at !== 1'b0) begin errs++; $display("FAIL starve_ready: ready %b at scrub grant exp 0", rdy_at); end
        checks++; if (scrub_q.size() - q0 !== 1 || scrub_q[q0] !== 2'd1) begin
            errs++; $display("FAIL starve_addr: scrub ops %0d exp 1 at addr 1", scrub_q.size() - q0); end
    endtask

    task automatic test_random();
        logic [63:0] d; logic e; int lat;
        logic [ADDR_W-1:0] a;
        for (int i = 0; i < DEPTH; i++) poke(ADDR_W'(i), {$urandom, $urandom}, rand_syn($urandom_range(0, 2)));
        for (int n = 0; n < 12; n++) begin
            a = ADDR_W'($urandom_range(0, DEPTH - 1));
            host_read(a, d, e, lat);
            checks++; if (lat !== 4 || d !== dat[a] || e !== (syn[a] >= 7'd72)) begin
                errs++; $display("FAIL rand_resp[%0d]: a %0d lat %0d data %h err %b exp 4 %h %b", n, a, lat, d, e, dat[a], syn[a] >= 7'd72); end
            note_err(a, syn[a]);
`ifdef HOST_WB_EN
            if (syn[a] != 7'd0 && syn[a] <= 7'd71) syn[a] = 7'd0;
`endif
            settle();
            checks++; if (int'(corr_cnt) !== exp_corr || int'(uncorr_cnt) !== exp_uncorr || last_err_addr !== exp_last) begin
                errs++; $display("FAIL rand_cnt[%0d]: c %0d u %0d last %0d exp %0d %0d %0d", n, corr_cnt, uncorr_cnt, last_err_addr, exp_corr, exp_uncorr, exp_last); end
        end
    endtask

    task automatic test_reset_mid_wb();
        logic [63:0] d; logic e; int lat, w;
        logic [63:0] v = {$urandom, $urandom};
        for (int i = 0; i < DEPTH; i++) poke(ADDR_W'(i), {$urandom, $urandom}, 7'd13);
        pulse_scrub();
        w = 0;
        while (!mem_we && w < 30) begin @(negedge clk); w++; end
        checks++; if (mem_we !== 1'b1) begin errs++; $display("FAIL rstwb_reach: mem_we %b exp 1", mem_we); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if (mem_en !== 1'b0 || mem_we !== 1'b0 || mem_wdata !== '0) begin
            errs++; $display("FAIL rstwb_mem: en %b we %b exp 0 0", mem_en, mem_we); end
        checks++; if (int'(corr_cnt) !== 0 || int'(uncorr_cnt) !== 0 || last_err_addr !== '0) begin
            errs++; $display("FAIL rstwb_cnt: c %0d u %0d last %0d exp 0 0 0", corr_cnt, uncorr_cnt, last_err_addr); end
        exp_corr = 0; exp_uncorr = 0; exp_last = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        poke(1, v, 7'd0);
        host_read(1, d, e, lat);
        checks++; if (lat !== 4 || d !== v || e !== 1'b0) begin
            errs++; $display("FAIL rstwb_first: lat %0d data %h err %b exp 4 %h 0", lat, d, e, v); end
        settle();
    endtask

    task automatic test_saturate();
        logic [63:0] d; logic e; int lat;
        logic [6:0] s;
        for (int n = 0; n < 5; n++) begin
            s = 7'($urandom_range(1, 71));
            poke(2, {$urandom, $urandom}, s);
            host_read(2, d, e, lat);
            note_err(2, s);
            settle();
            checks++; if (int'(corr_cnt) !== exp_corr) begin
                errs++; $display("FAIL sat[%0d]: corr %0d exp %0d", n, corr_cnt, exp_corr); end
        end
    endtask

    task automatic test_wrap();
        int q0, p0, w;
        for (int i = 0; i < DEPTH; i++) poke(ADDR_W'(i), {$urandom, $urandom}, 7'd0);
        #3; q0 = scrub_q.size(); p0 = pass_cnt;
        @(negedge clk);
        scrub_en = 1'b1;
        w = 0;
        while (scrub_q.size() < q0 + 5 && w < 200) begin @(negedge clk); w++; end
        #3;
        checks++; if (scrub_q.size() < q0 + 5) begin errs++; $display("FAIL wrap_ops: got %0d exp 5", scrub_q.size() - q0); end
        else begin
            for (int k = 0; k < 5; k++) begin
                checks++; if (scrub_q[q0 + k] !== ADDR_W'(k % DEPTH)) begin
                    errs++; $display("FAIL wrap_addr[%0d]: got %0d exp %0d", k, scrub_q[q0 + k], k % DEPTH); end
            end
        end
        checks++; if (pass_cnt - p0 !== 1) begin errs++; $display("FAIL wrap_pass: pulses %0d exp 1", pass_cnt - p0); end
        scrub_en = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_clean_read();
        test_host_corr();
        test_uncorr();
        test_scrub_corr();
        test_starve();
        test_random();
        test_reset_mid_wb();
        test_saturate();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
